// File: rtl/fp32_adder_pkg.sv
// Shared types and constants for the binary32 add/subtract controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp32_adder_pkg;

  // Controller sequence: capture, align, request, wait, normalise, pack, hold.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NORM  = 3'd4,
    ST_PACK  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Bit positions inside the Exc output.
  localparam int EXC_OVF = 0;
  localparam int EXC_UNF = 1;
  localparam int EXC_INV = 2;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  // Raw binary32 field view.
  typedef struct packed {
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] frac;
  } fp32_t;

  // Leading-zero count of a 24-bit mantissa; an all-zero word yields 24.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_adder_ctrl_if.sv
// Caller-side bus of the binary32 adder: operands, mode, result and flags.
// Latency: n/a (wiring only).
// Backpressure: 4-phase; Data_valid is held until Dataout_valid, then dropped.
interface fp32_adder_ctrl_if;
  logic [31:0] Datain1;
  logic [31:0] Datain2;
  logic        Data_valid;
  logic [2:0]  Mode;
  logic [4:0]  Debug;
  logic [31:0] Dataout;
  logic        Dataout_valid;
  logic [2:0]  Exc;

  modport master (
    output Datain1, Datain2, Data_valid, Mode, Debug,
    input  Dataout, Dataout_valid, Exc
  );

  modport slave (
    input  Datain1, Datain2, Data_valid, Mode, Debug,
    output Dataout, Dataout_valid, Exc
  );
endinterface

// File: rtl/fp32_adder_ctrl_mant_adder.sv
// Registered mantissa adder: Z = A + B + CIN with carry out, REQ/ACK handshaked.
// Latency: 1 cycle; ACK follows REQ one cycle late in both directions.
// Backpressure: none; the requester holds REQ until it sees ACK.
module mant_adder_24b #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] z_o,
  output logic         cout_o,
  output logic         ack_o
);

  logic [W-1:0] z_q;
  logic         cout_q;
  logic         ack_q;

  // Sum is recomputed every cycle REQ is high; ACK is REQ delayed by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      z_q    <= '0;
      cout_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= req_i;
      if (req_i) begin
        {cout_q, z_q} <= {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
      end
    end
  end

  assign z_o    = z_q;
  assign cout_o = cout_q;
  assign ack_o  = ack_q;

endmodule

// File: rtl/fp32_adder_ctrl.sv
// Binary32 add/subtract controller (truncating), driving mant_adder_24b over REQ/ACK.
// Latency: 6 cycles after the capturing edge; NaN/inf operands finish after ALIGN.
// Backpressure: result held in DONE until the caller drops Data_valid.
// Optional debug readback on Dataout is built when FP32_ADDER_DEBUG_EN is defined.
module fp32_adder_ctrl
  import fp32_adder_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                CLK,
  input  logic                RST,
  fp32_adder_ctrl_if.slave    bus
);

  localparam int XW = EXP_W + 2;

  state_e state_q, state_d;
  logic   req_q, req_d;
  logic   ack;

  logic [31:0]             a_q, b_q;
  logic                    mode_q;
  logic [EXP_W-1:0]        ea_q, diff_q;
  logic [MANT_W-1:0]       ma_q, mb_q;
  logic                    sign_q, sub_q;
  logic [MANT_W-1:0]       z_q, z_add;
  logic                    cout_q, cout_add;
  logic [MANT_W-1:0]       mant_n_q;
  logic signed [XW-1:0]    exp_n_q;
  logic                    zero_q;
  logic [31:0]             dout_q;
  logic [2:0]              exc_q;

  // Align-stage combinational results
  fp32_t             fa, fb;
  logic              sb_eff, a_nan, b_nan, a_inf, b_inf, swap, special;
  logic [MANT_W-1:0] ma, mb, big_m, sml_m, mb_d;
  logic [EXP_W-1:0]  big_e, sml_e, diff_d;
  logic              big_s, sub_d;
  logic [31:0]       spec_word;
  logic [2:0]        spec_exc;

  // Normalise/pack combinational results
  logic [4:0]           lz;
  logic [MANT_W-1:0]    mant_n_d;
  logic signed [XW-1:0] exp_n_d;
  logic                 zero_d;
  logic [31:0]          pack_word;
  logic [2:0]           pack_exc;

  mant_adder_24b #(.W(MANT_W)) u_adder (
    .clk_i  (CLK),
    .rst_i  (RST),
    .req_i  (req_q),
    .a_i    (ma_q),
    .b_i    (sub_q ? ~mb_q : mb_q),
    .cin_i  (sub_q),
    .z_o    (z_add),
    .cout_o (cout_add),
    .ack_o  (ack)
  );

  // State register and adder request flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic; REQ is raised in REQ and dropped once ACK is seen.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE:  if (bus.Data_valid) state_d = ST_ALIGN;
      ST_ALIGN: state_d = special ? ST_DONE : ST_REQ;
      ST_REQ: begin
        req_d   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = ST_NORM;
        end
      end
      ST_NORM:  state_d = ST_PACK;
      ST_PACK:  state_d = ST_DONE;
      ST_DONE:  if (!bus.Data_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Unpack, classify specials, order by magnitude and align the smaller operand.
  always_comb begin
    fa      = a_q;
    fb      = b_q;
    sb_eff  = fb.sign ^ mode_q;
    a_nan   = (fa.expo == 8'hFF) && (fa.frac != '0);
    b_nan   = (fb.expo == 8'hFF) && (fb.frac != '0);
    a_inf   = (fa.expo == 8'hFF) && (fa.frac == '0);
    b_inf   = (fb.expo == 8'hFF) && (fb.frac == '0);
    special = a_nan | b_nan | a_inf | b_inf;
    // Denormals collapse to zero by dropping the mantissa entirely.
    ma      = (fa.expo == '0) ? '0 : {1'b1, fa.frac};
    mb      = (fb.expo == '0) ? '0 : {1'b1, fb.frac};
    swap    = {fb.expo, mb} > {fa.expo, ma};
    if (swap) begin
      big_e = fb.expo; big_m = mb; big_s = sb_eff;
      sml_e = fa.expo; sml_m = ma;
    end else begin
      big_e = fa.expo; big_m = ma; big_s = fa.sign;
      sml_e = fb.expo; sml_m = mb;
    end
    diff_d = big_e - sml_e;
    mb_d   = (diff_d >= EXP_W'(MANT_W)) ? '0 : (sml_m >> diff_d);
    sub_d  = mode_q ^ fa.sign ^ fb.sign;
    spec_word = '0;
    spec_exc  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && sub_d)) begin
      spec_word         = QNAN;
      spec_exc[EXC_INV] = 1'b1;
    end else if (a_inf) begin
      spec_word = {fa.sign, POS_INF[30:0]};
    end else if (b_inf) begin
      spec_word = {sb_eff, POS_INF[30:0]};
    end
  end

  // Normalise the adder result and pack it with range checks.
  always_comb begin
    lz = lzc24(z_q);
    if (!sub_q && cout_q) begin
      mant_n_d = {1'b1, z_q[MANT_W-1:1]};
      exp_n_d  = $signed({2'b00, ea_q}) + XW'(1);
      zero_d   = 1'b0;
    end else begin
      mant_n_d = z_q << lz;
      exp_n_d  = $signed({2'b00, ea_q}) - $signed({5'b00000, lz});
      zero_d   = (z_q == '0);
    end
    pack_word = {sign_q, exp_n_q[EXP_W-1:0], mant_n_q[MANT_W-2:0]};
    pack_exc  = '0;
    if (zero_q) begin
      pack_word = '0;
    end else if (exp_n_q > XW'(254)) begin
      pack_word         = {sign_q, POS_INF[30:0]};
      pack_exc[EXC_OVF] = 1'b1;
    end else if (exp_n_q < XW'(1)) begin
      pack_word         = {sign_q, 31'd0};
      pack_exc[EXC_UNF] = 1'b1;
    end
  end

  // Datapath registers, each loaded in the state that produces it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q <= '0; b_q <= '0; mode_q <= 1'b0;
      ea_q <= '0; diff_q <= '0; ma_q <= '0; mb_q <= '0;
      sign_q <= 1'b0; sub_q <= 1'b0;
      z_q <= '0; cout_q <= 1'b0;
      mant_n_q <= '0; exp_n_q <= '0; zero_q <= 1'b0;
      dout_q <= '0; exc_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Data_valid) begin
            a_q    <= bus.Datain1;
            b_q    <= bus.Datain2;
            mode_q <= bus.Mode[0];
          end
        end
        ST_ALIGN: begin
          ea_q   <= big_e;
          diff_q <= diff_d;
          ma_q   <= big_m;
          mb_q   <= mb_d;
          sign_q <= big_s;
          sub_q  <= sub_d;
          if (special) begin
            dout_q <= spec_word;
            exc_q  <= spec_exc;
          end
        end
        ST_WAIT: begin
          if (ack) begin
            z_q    <= z_add;
            cout_q <= cout_add;
          end
        end
        ST_NORM: begin
          mant_n_q <= mant_n_d;
          exp_n_q  <= exp_n_d;
          zero_q   <= zero_d;
        end
        ST_PACK: begin
          dout_q <= pack_word;
          exc_q  <= pack_exc;
        end
        default: ;
      endcase
    end
  end

  assign bus.Dataout_valid = (state_q == ST_DONE);
  assign bus.Exc           = exc_q;

  logic unused_mode;
  assign unused_mode = ^bus.Mode[2:1];

`ifdef FP32_ADDER_DEBUG_EN
  logic [31:0] dbg_word;

  // Internal word selected for readback while holding a result.
  always_comb begin
    dbg_word = '0;
    case (bus.Debug[1:0])
      2'd0:    dbg_word = 32'({state_q, diff_q});
      2'd1:    dbg_word = 32'(ma_q);
      2'd2:    dbg_word = 32'(mb_q);
      default: dbg_word = 32'({cout_q, z_q});
    endcase
  end

  assign bus.Dataout = (bus.Debug[4] && (state_q == ST_DONE)) ? dbg_word : dout_q;

  logic unused_dbg;
  assign unused_dbg = ^bus.Debug[3:2];
`else
  assign bus.Dataout = dout_q;

  logic unused_dbg;
  assign unused_dbg = ^{bus.Debug, diff_q};
`endif

endmodule

// File: tb/tb_fp32_adder_ctrl.sv
// Directed bench for fp32_adder_ctrl: arithmetic vectors, specials, handshake, reset.
// Latency: checks 6-cycle normal path and short special path.
// Backpressure: exercises holding Data_valid in DONE and mid-operation reset.
module tb_fp32_adder_ctrl;
  import fp32_adder_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fp32_adder_ctrl_if bus_if ();

  fp32_adder_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Drive one request and wait (bounded) for the result; lat counts edges after the sampling edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode,
                       output logic [31:0] dout, output logic [2:0] exc, output int lat);
    @(negedge CLK);
    bus_if.Datain1    = a;
    bus_if.Datain2    = b;
    bus_if.Mode       = mode;
    bus_if.Data_valid = 1'b1;
    @(posedge CLK);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      #1;
      if (bus_if.Dataout_valid) begin
        lat = i;
        break;
      end
    end
    dout = bus_if.Dataout;
    exc  = bus_if.Exc;
  endtask

  task automatic release_op();
    @(negedge CLK);
    bus_if.Data_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    bus_if.Datain1 = 32'h3F80_0000; bus_if.Datain2 = 32'h3F80_0000;
    bus_if.Mode = 3'b000; bus_if.Debug = 5'd0; bus_if.Data_valid = 1'b1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (bus_if.Dataout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want %h", bus_if.Dataout, 32'h0); end
    checks++; if (bus_if.Dataout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_if.Dataout_valid); end
    checks++; if (bus_if.Exc !== 3'b000) begin errors++; $display("FAIL reset_exc got %b want 000", bus_if.Exc); end
    checks++; if (dut.req_q !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dut.req_q); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, ST_IDLE); end
    @(negedge CLK);
    bus_if.Data_valid = 1'b0;
    RST = 1'b0;
    @(posedge CLK);
  endtask

  task automatic test_add();
    logic [31:0] d; logic [2:0] e; int lat;
    // 1.0 + 1.0 = 2.0, carry-out path
    do_op(32'h3F80_0000, 32'h3F80_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL add_1p1 got %h want %h", d, 32'h4000_0000); end
    checks++; if (e !== 3'b000) begin errors++; $display("FAIL add_1p1_exc got %b want 000", e); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL add_1p1_latency got %0d want 6", lat); end
    release_op();
    checks++; if (bus_if.Dataout_valid !== 1'b0) begin errors++; $display("FAIL add_release got %b want 0", bus_if.Dataout_valid); end
    // Reserved Mode bits set: still an add
    do_op(32'h3F80_0000, 32'h3F80_0000, 3'b110, d, e, lat);
    checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL add_mode_reserved got %h want %h", d, 32'h4000_0000); end
    release_op();
  endtask

  task automatic test_sub();
    logic [31:0] d; logic [2:0] e; int lat;
    // 2.5 + -1.0 = 1.5
    do_op(32'h4020_0000, 32'hBF80_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'h3FC0_0000) begin errors++; $display("FAIL sub_2p5m1 got %h want %h", d, 32'h3FC0_0000); end
    checks++; if (e !== 3'b000) begin errors++; $display("FAIL sub_2p5m1_exc got %b want 000", e); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL sub_2p5m1_latency got %0d want 6", lat); end
    release_op();
    // 1.5 - 1.5 = +0 exactly
    do_op(32'h3FC0_0000, 32'h3FC0_0000, 3'b001, d, e, lat);
    checks++; if (d !== 32'h0000_0000) begin errors++; $display("FAIL sub_cancel got %h want %h", d, 32'h0); end
    checks++; if (e !== 3'b000) begin errors++; $display("FAIL sub_cancel_exc got %b want 000", e); end
    release_op();
    // -2.0 + 1.0 = -1.0 (larger operand is A, negative)
    do_op(32'hC000_0000, 32'h3F80_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'hBF80_0000) begin errors++; $display("FAIL sub_neg_a got %h want %h", d, 32'hBF80_0000); end
    release_op();
    // 1.0 - 2.0 = -1.0 (swap, sign from negated B)
    do_op(32'h3F80_0000, 32'h4000_0000, 3'b001, d, e, lat);
    checks++; if (d !== 32'hBF80_0000) begin errors++; $display("FAIL sub_swap got %h want %h", d, 32'hBF80_0000); end
    release_op();
  endtask

  task automatic test_boundary();
    logic [31:0] d; logic [2:0] e; int lat;
    // max + max overflows to +inf
    do_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000, d, e, lat);
    checks++; if (d !== 32'h7F80_0000) begin errors++; $display("FAIL ovf got %h want %h", d, 32'h7F80_0000); end
    checks++; if (e !== 3'b001) begin errors++; $display("FAIL ovf_exc got %b want 001", e); end
    release_op();
    // 1.5*2^-126 - 1.0*2^-126 normalises below exponent 1
    do_op(32'h00C0_0000, 32'h0080_0000, 3'b001, d, e, lat);
    checks++; if (d !== 32'h0000_0000) begin errors++; $display("FAIL unf got %h want %h", d, 32'h0); end
    checks++; if (e !== 3'b010) begin errors++; $display("FAIL unf_exc got %b want 010", e); end
    release_op();
    // 1.0 + 1.5*2^-23: shift by 23 keeps one bit, truncation drops the half ulp
    do_op(32'h3F80_0000, 32'h3440_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'h3F80_0001) begin errors++; $display("FAIL trunc got %h want %h", d, 32'h3F80_0001); end
    release_op();
    // 1.0 + 2^-30: exponent difference 30 shifts B to zero
    do_op(32'h3F80_0000, 32'h3080_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'h3F80_0000) begin errors++; $display("FAIL shift_ge24 got %h want %h", d, 32'h3F80_0000); end
    release_op();
    // Denormal B treated as zero
    do_op(32'h3F80_0000, 32'h0000_0001, 3'b000, d, e, lat);
    checks++; if (d !== 32'h3F80_0000) begin errors++; $display("FAIL denorm got %h want %h", d, 32'h3F80_0000); end
    checks++; if (e !== 3'b000) begin errors++; $display("FAIL denorm_exc got %b want 000", e); end
    release_op();
  endtask

  task automatic test_special_handshake();
    logic [31:0] d; logic [2:0] e; int lat; logic held_ok;
    // inf + -inf is invalid
    do_op(32'h7F80_0000, 32'hFF80_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'h7FC0_0000) begin errors++; $display("FAIL inv_infinf got %h want %h", d, 32'h7FC0_0000); end
    checks++; if (e !== 3'b100) begin errors++; $display("FAIL inv_infinf_exc got %b want 100", e); end
    // Special results skip the adder: ready one ALIGN cycle after sampling
    checks++; if (lat < 1 || lat > 2) begin errors++; $display("FAIL special_latency got %0d want 1..2", lat); end
    held_ok = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      if (bus_if.Dataout_valid !== 1'b1 || bus_if.Dataout !== 32'h7FC0_0000) held_ok = 1'b0;
    end
    checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL hold_done got %b want 1", held_ok); end
    @(negedge CLK);
    bus_if.Data_valid = 1'b0;
    #1;
    checks++; if (bus_if.Dataout_valid !== 1'b1) begin errors++; $display("FAIL drop_before_edge got %b want 1", bus_if.Dataout_valid); end
    @(posedge CLK); #1;
    checks++; if (bus_if.Dataout_valid !== 1'b0) begin errors++; $display("FAIL drop_after_edge got %b want 0", bus_if.Dataout_valid); end
    // NaN operand
    do_op(32'h7F80_0001, 32'h3F80_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'h7FC0_0000 || e !== 3'b100) begin errors++; $display("FAIL nan got %h/%b want 7fc00000/100", d, e); end
    release_op();
    // inf + finite
    do_op(32'h7F80_0000, 32'h3F80_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'h7F80_0000 || e !== 3'b000) begin errors++; $display("FAIL inf_fin got %h/%b want 7f800000/000", d, e); end
    release_op();
    // finite - inf = -inf
    do_op(32'h3F80_0000, 32'h7F80_0000, 3'b001, d, e, lat);
    checks++; if (d !== 32'hFF80_0000 || e !== 3'b000) begin errors++; $display("FAIL fin_minus_inf got %h/%b want ff800000/000", d, e); end
    release_op();
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] d; logic [2:0] e; int lat; logic saw_valid;
    @(negedge CLK);
    bus_if.Datain1 = 32'h3F80_0000; bus_if.Datain2 = 32'h3F80_0000;
    bus_if.Mode = 3'b000; bus_if.Data_valid = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK); #1;
    checks++; if (dut.state_q !== ST_WAIT) begin errors++; $display("FAIL rst_wait_reach got %0d want %0d", dut.state_q, ST_WAIT); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rst_wait_state got %0d want %0d", dut.state_q, ST_IDLE); end
    checks++; if (dut.req_q !== 1'b0) begin errors++; $display("FAIL rst_wait_req got %b want 0", dut.req_q); end
    @(negedge CLK);
    bus_if.Data_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    saw_valid = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (bus_if.Dataout_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_no_result got %b want 0", saw_valid); end
    do_op(32'h3F80_0000, 32'h3F80_0000, 3'b000, d, e, lat);
    checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL rst_wait_retry got %h want %h", d, 32'h4000_0000); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL rst_wait_retry_latency got %0d want 6", lat); end
    release_op();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_boundary();
    test_special_handshake();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
